cfglut_gen: RTL and testbench

Parametrised, run-time reconfigurable K-input LUT model for Verilator simulation of Xilinx netlists, generalising the fixed-function LUT primitives to the CFGLUT5 style. The truth table is held in a register that reset loads from INIT and that is reconfigured serially, one bit per enabled clock. It drives a full K-input output, a lower-half (K-1)-input output and a cascade output for chaining tables. It sits in the primitive library beside the combinational LUT models and is instantiated wherever a netlist contains reconfigurable LUTs.

---
 rtl/cfglut_gen.sv | 55 +++++
 tb/tb_cfglut_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cfglut_gen.sv
// cfglut_gen: run-time reconfigurable K-input LUT, CFGLUT5 style, serial config
//   Params : K (2..6 inputs), INIT (reset truth table, bits [2^K-1:0] used)
//   Inputs : CLK, RST (async, active-high), CE (shift enable), CDI (serial data),
//            I (LUT address), LOAD/LOAD_DATA (parallel load, CFGLUT_PARALLEL_LOAD_EN only)
//   Outputs: O = table[I], OL = lower-half lookup, CDO = table MSB (cascade),
//            CFG_VALID = table holds a complete configuration
//   Macro  : CFGLUT_PARALLEL_LOAD_EN enables the LOAD/LOAD_DATA parallel load path
module cfglut_gen #(
   parameter int K = 5,
   parameter logic [63:0] INIT = 64'h0
) (
   input  logic CLK,
   input  logic RST,
   input  logic CE,
   input  logic CDI,
   input  logic [K-1:0] I,
`ifdef CFGLUT_PARALLEL_LOAD_EN
   input  logic LOAD,
   input  logic [(1<<K)-1:0] LOAD_DATA,
`endif
   output logic O,
   output logic OL,
   output logic CDO,
   output logic CFG_VALID
);
   localparam int N = 1 << K;
   if (K < 2 || K > 6) begin : g_bad_k
      $error("cfglut_gen: K must be in 2..6");
   end
   logic [N-1:0] tbl;
   logic [K:0] cnt;
   logic last;
   assign last = cnt == (K+1)'(N-1);
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         tbl <= INIT[N-1:0];
         cnt <= '0;
         CFG_VALID <= 1'b1;
      end
`ifdef CFGLUT_PARALLEL_LOAD_EN
      else if (LOAD) begin
         tbl <= LOAD_DATA;
         cnt <= '0;
         CFG_VALID <= 1'b1;
      end
`endif
      else if (CE) begin
         tbl <= {tbl[N-2:0], CDI};
         cnt <= last ? '0 : cnt + (K+1)'(1);
         CFG_VALID <= last;
      end
   assign O = tbl[I];
   assign OL = tbl[{1'b0, I[K-2:0]}];
   assign CDO = tbl[N-1];
endmodule

// File: tb/tb_cfglut_gen.sv
// tb_cfglut_gen: scoreboard bench for cfglut_gen (K=5), two instances cascaded
module tb_cfglut_gen;
   logic CLK = 1'b0;
   logic RST, CE, CDI;
   logic [4:0] I;
   logic o_a, ol_a, cdo_a, v_a, o_b, ol_b, cdo_b, v_b;
`ifdef CFGLUT_PARALLEL_LOAD_EN
   logic LOAD = 1'b0;
   logic [31:0] LOAD_DATA = '0;
`endif
   always #5 CLK = ~CLK;

   cfglut_gen #(.K(5), .INIT(64'hDEADBEEF)) dut_a (
      .CLK(CLK), .RST(RST), .CE(CE), .CDI(CDI), .I(I),
`ifdef CFGLUT_PARALLEL_LOAD_EN
      .LOAD(LOAD), .LOAD_DATA(LOAD_DATA),
`endif
      .O(o_a), .OL(ol_a), .CDO(cdo_a), .CFG_VALID(v_a));

   cfglut_gen #(.K(5), .INIT(64'h0)) dut_b (
      .CLK(CLK), .RST(RST), .CE(CE), .CDI(cdo_a), .I(I),
`ifdef CFGLUT_PARALLEL_LOAD_EN
      .LOAD(1'b0), .LOAD_DATA(32'h0),
`endif
      .O(o_b), .OL(ol_b), .CDO(cdo_b), .CFG_VALID(v_b));

   typedef struct {
      string name;
      int kind;
      logic [31:0] exp;
   } chk_t;
   chk_t q[$];
   chk_t c;
   logic [31:0] act;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] actual(int k);
      case (k)
         0: return {31'b0, o_a};
         1: return {31'b0, ol_a};
         2: return {31'b0, cdo_a};
         3: return {31'b0, v_a};
         4: return dut_a.tbl;
         5: return dut_b.tbl;
         6: return {31'b0, v_b};
         7: return {31'b0, cdo_b};
         8: return {31'b0, o_b};
         default: return {31'b0, ol_b};
      endcase
   endfunction

   // monitor: drains every expectation posted since the last falling edge
   always @(negedge CLK)
      while (q.size() > 0) begin
         c = q.pop_front();
         act = actual(c.kind);
         n_cmp++;
         if (act !== c.exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", c.name, act, c.exp);
         end
      end

   task automatic chk(string name, int kind, logic [31:0] exp, logic [4:0] addr);
      I = addr;
      q.push_back('{name, kind, exp});
      @(negedge CLK);
      #1;
   endtask

   task automatic step(logic ce, logic cdi);
      CE = ce;
      CDI = cdi;
      @(posedge CLK);
      #1;
      CE = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      #1;
      RST = 1'b0;
   endtask

   logic [63:0] v;

   initial begin
      RST = 1'b1; CE = 1'b0; CDI = 1'b0; I = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst_o_i00", 0, 32'd1, 5'h00);
      chk("rst_o_i04", 0, 32'd0, 5'h04);
      chk("rst_o_i11", 0, 32'd0, 5'h11);
      chk("rst_ol_i11", 1, 32'd1, 5'h11);
      chk("rst_cdo", 2, 32'd1, 5'h00);
      chk("rst_valid", 3, 32'd1, 5'h00);
      chk("rst_tbl", 4, 32'hDEADBEEF, 5'h00);
      // continuous shift of 32'h12345678, MSB first
      v = 64'h12345678;
      for (int i = 31; i >= 0; i--) begin
         step(1'b1, v[i]);
         chk("shift_valid", 3, (i == 0) ? 32'd1 : 32'd0, 5'h00);
      end
      chk("shift_tbl", 4, 32'h12345678, 5'h00);
      chk("shift_o_i03", 0, 32'd1, 5'h03);
      chk("shift_ol_i03", 1, 32'd1, 5'h03);
      chk("shift_o_i13", 0, 32'd0, 5'h13);
      chk("shift_ol_i13", 1, 32'd1, 5'h13);
      chk("shift_cdo", 2, 32'd0, 5'h00);
      // reset mid-shift restores INIT before the next edge
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      chk("part_valid", 3, 32'd0, 5'h00);
      RST = 1'b1;
      q.push_back('{"midrst_tbl", 4, 32'hDEADBEEF});
      q.push_back('{"midrst_valid", 3, 32'd1});
      q.push_back('{"midrst_cdo", 2, 32'd1});
      @(negedge CLK);
      #1 RST = 1'b0;
      for (int i = 0; i < 31; i++) step(1'b1, 1'b0);
      chk("rerise_31", 3, 32'd0, 5'h00);
      step(1'b1, 1'b0);
      chk("rerise_32", 3, 32'd1, 5'h00);
      chk("rerise_tbl", 4, 32'h0, 5'h00);
      // CE gaps: CE=0 edges must hold table and count
      do_reset();
      v = 64'hCAFEF00D;
      for (int i = 31; i >= 0; i--) begin
         step(1'b1, v[i]);
         step(1'b0, ~v[i]);
         if (i == 16) begin
            chk("gap_half_tbl", 4, 32'hBEEFCAFE, 5'h00);
            chk("gap_half_valid", 3, 32'd0, 5'h00);
         end
      end
      chk("gap_tbl", 4, 32'hCAFEF00D, 5'h00);
      chk("gap_valid", 3, 32'd1, 5'h00);
      // cascade: 64-bit chain through dut_a into dut_b
      do_reset();
      v = 64'h0123456789ABCDEF;
      for (int i = 63; i >= 0; i--) step(1'b1, v[i]);
      chk("casc_tbl_a", 4, 32'h89ABCDEF, 5'h00);
      chk("casc_tbl_b", 5, 32'h01234567, 5'h00);
      chk("casc_valid_b", 6, 32'd1, 5'h00);
      chk("casc_cdo_b", 7, 32'd0, 5'h00);
      chk("casc_o_b", 8, 32'd0, 5'h12);
      chk("casc_ol_b", 9, 32'd1, 5'h12);
`ifdef CFGLUT_PARALLEL_LOAD_EN
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
      LOAD = 1'b1;
      LOAD_DATA = 32'hA5A5A5A5;
      step(1'b1, 1'b1);
      LOAD = 1'b0;
      chk("load_tbl", 4, 32'hA5A5A5A5, 5'h00);
      chk("load_valid", 3, 32'd1, 5'h00);
      for (int i = 0; i < 31; i++) step(1'b1, 1'b0);
      chk("load_cnt_31", 3, 32'd0, 5'h00);
      step(1'b1, 1'b0);
      chk("load_cnt_32", 3, 32'd1, 5'h00);
`endif
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
      #1;
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
